// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM states and
// byte-lane helpers used for store enables and misalignment detection.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave):
// request with ready handshake, response flagged by rvalid.
interface mem_access_stage_if #(
  parameter int XLEN = 64
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [7:0]      be;
  logic            ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_load_align.sv
// Combinational load alignment: moves the addressed lane down to bit 0 and
// sign- or zero-extends it according to funct3.
module dmem_load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted_s;

  assign shifted_s = rdata_i >> {off_i, 3'b000};

  // Lanes beyond the doubleword shift in as zero, so a misaligned load extends what remains.
  always_comb begin
    result_o = shifted_s;
    case (funct3_i)
      F3_B:    result_o = {{56{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    result_o = {{48{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    result_o = {{32{shifted_s[31]}}, shifted_s[31:0]};
      F3_D:    result_o = shifted_s;
      F3_BU:   result_o = {56'd0, shifted_s[7:0]};
      F3_HU:   result_o = {48'd0, shifted_s[15:0]};
      F3_WU:   result_o = {32'd0, shifted_s[31:0]};
      default: result_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV64 pipeline: issues one data-memory access per load/store,
// stalls until it completes and returns the aligned load result.
// Optional DMEM_TIMEOUT_EN aborts a WAIT that exceeds TIMEOUT_CYCLES and raises mem_err.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic [2:0]        ex_mem_funct3,
  input  logic [XLEN-1:0]   ex_mem_alu,
  input  logic [XLEN-1:0]   ex_mem_wdata,
  mem_access_stage_if.master dmem,
  output logic [XLEN-1:0]   mem_read_data,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_err
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      be_q, be_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            mem_op_s;
  logic [2:0]      off_s;
  logic [3:0]      end_lane_s;
  logic [7:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] load_data_s;

  assign mem_op_s   = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);
  assign off_s      = ex_mem_alu[2:0];
  assign end_lane_s = {1'b0, off_s} + size_bytes(ex_mem_funct3[1:0]);
  assign be_s       = size_mask(ex_mem_funct3[1:0]) << off_s;
  assign wdata_s    = ex_mem_wdata << {off_s, 3'b000};

  dmem_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dmem.rdata),
    .off_i    (off_s),
    .funct3_i (ex_mem_funct3),
    .result_o (load_data_s)
  );

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Wait counter restarts on every accepted request and counts WAIT cycles.
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      ST_REQ:  cnt_d = 8'd0;
      ST_WAIT: cnt_d = cnt_q + 8'd1;
      default: cnt_d = cnt_q;
    endcase
  end
`else
  logic [7:0] unused_timeout_s;
  assign unused_timeout_s = TIMEOUT_LIM;
`endif

  // Next-state logic; load data is captured on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
`ifdef DMEM_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem.ready && dmem.rvalid) begin
          state_d = ST_DONE;
          rdata_d = ex_mem_memread ? load_data_s : rdata_q;
        end else if (dmem.ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem.rvalid) begin
          state_d = ST_DONE;
          rdata_d = ex_mem_memread ? load_data_s : rdata_q;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LIM) begin
          state_d = ST_DONE;
          rdata_d = {XLEN{1'b0}};
          err_d   = 1'b1;
        end
`endif
        else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are registered and only non-zero while the request is presented.
  always_comb begin
    req_d   = (state_d == ST_REQ);
    we_d    = 1'b0;
    addr_d  = {XLEN{1'b0}};
    wdata_d = {XLEN{1'b0}};
    be_d    = 8'h00;
    if (req_d) begin
      we_d    = ex_mem_memwrite;
      addr_d  = {ex_mem_alu[XLEN-1:3], 3'b000};
      wdata_d = ex_mem_memwrite ? wdata_s : {XLEN{1'b0}};
      be_d    = be_s;
    end else begin
      we_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {XLEN{1'b0}};
      wdata_q <= {XLEN{1'b0}};
      be_q    <= 8'h00;
      rdata_q <= {XLEN{1'b0}};
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

  // Stall is raised in the same cycle a memory op appears, and drops with reset.
  assign mem_stall = reset & (((state_q == ST_IDLE) & mem_op_s) |
                              (state_q == ST_REQ) | (state_q == ST_WAIT));
  assign mem_misalign  = reset & mem_op_s & (end_lane_s > 4'd8);
  assign mem_read_data = rdata_q;

`ifdef DMEM_TIMEOUT_EN
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-level
// transaction model; the timeout scenario runs only with DMEM_TIMEOUT_EN.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_mem_valid = 1'b0;
  logic        ex_mem_memread = 1'b0;
  logic        ex_mem_memwrite = 1'b0;
  logic [2:0]  ex_mem_funct3 = 3'b000;
  logic [63:0] ex_mem_alu = 64'd0;
  logic [63:0] ex_mem_wdata = 64'd0;
  logic [63:0] mem_read_data;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_err;

  int checks = 0;
  int passed = 0;
  logic [63:0] model_rd = 64'd0;

  mem_access_stage_if #(.XLEN(64)) dmem ();

  mem_access_stage #(.XLEN(64), .TIMEOUT_CYCLES(255)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_mem_valid    (ex_mem_valid),
    .ex_mem_memread  (ex_mem_memread),
    .ex_mem_memwrite (ex_mem_memwrite),
    .ex_mem_funct3   (ex_mem_funct3),
    .ex_mem_alu      (ex_mem_alu),
    .ex_mem_wdata    (ex_mem_wdata),
    .dmem            (dmem),
    .mem_read_data   (mem_read_data),
    .mem_stall       (mem_stall),
    .mem_misalign    (mem_misalign),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] raw, input int off, input logic [2:0] f3);
    int n;
    logic [63:0] r;
    n = nbytes(f3);
    r = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = raw[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] exp_be(input int off, input logic [2:0] f3);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < nbytes(f3); i++)
      if (off + i < 8) b[off+i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input int off);
    logic [63:0] w;
    w = 64'd0;
    for (int i = off; i < 8; i++) w[8*i +: 8] = wd[8*(i-off) +: 8];
    return w;
  endfunction

  // One access: memory holds ready low for rdelay request cycles, then answers
  // lat cycles after acceptance (0 = same cycle, negative = never).
  task automatic run_txn(input string name, input bit is_load, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] raw, input int rdelay, input int lat);
    int  reqcnt = 0, waitcnt = 0, stalls = 0, cyc = 0, off;
    bit  accepted = 0, responded = 0, done = 0, req_checked = 0, req_now;
    bit  exp_err;
    logic [63:0] exp_rd;
    off     = int'(addr[2:0]);
    exp_err = (lat < 0);
    if (exp_err) exp_rd = 64'd0;
    else if (is_load) exp_rd = exp_load(raw, off, f3);
    else exp_rd = model_rd;
    ex_mem_valid = 1'b1; ex_mem_memread = is_load; ex_mem_memwrite = !is_load;
    ex_mem_funct3 = f3; ex_mem_alu = addr; ex_mem_wdata = wd;
    while (!done && cyc < 1000) begin
      req_now = dmem.req;
      if (req_now && !accepted) begin
        dmem.ready  = (reqcnt >= rdelay);
        dmem.rvalid = dmem.ready ? (lat == 0) : 1'($urandom_range(0, 1));
        dmem.rdata  = (dmem.ready && lat == 0) ? raw : rand64();
        accepted    = dmem.ready;
        responded   = dmem.ready && (lat == 0);
        reqcnt++;
      end else if (accepted && !responded) begin
        waitcnt++;
        dmem.ready  = 1'($urandom_range(0, 1));
        dmem.rvalid = (lat > 0 && waitcnt == lat);
        dmem.rdata  = dmem.rvalid ? raw : rand64();
        responded   = dmem.rvalid;
      end else begin
        dmem.ready  = 1'($urandom_range(0, 1));
        dmem.rvalid = 1'($urandom_range(0, 1));
        dmem.rdata  = rand64();
      end
      @(negedge clk);
      if (cyc == 0)
        check_eq({name, "_misalign"}, 64'(mem_misalign), 64'(off + nbytes(f3) > 8));
      if (req_now && !req_checked) begin
        req_checked = 1;
        check_eq({name, "_addr"}, dmem.addr, {addr[63:3], 3'b000});
        check_eq({name, "_we"}, 64'(dmem.we), 64'(!is_load));
        check_eq({name, "_be"}, 64'(dmem.be), 64'(exp_be(off, f3)));
        if (!is_load) check_eq({name, "_wdata"}, dmem.wdata, exp_wdata(wd, off));
      end
      if (mem_stall) stalls++;
      else begin
        done = 1;
        check_eq({name, "_rdata"}, mem_read_data, exp_rd);
        check_eq({name, "_err"}, 64'(mem_err), 64'(exp_err));
        check_eq({name, "_req_done"}, 64'(dmem.req), 64'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check_eq({name, "_timeout"}, 64'(done), 64'd1);
    check_eq({name, "_stall_cycles"}, 64'(stalls), 64'(2 + rdelay + (lat < 0 ? 255 : lat)));
    model_rd = exp_rd;
    ex_mem_valid = 1'b0; ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
    dmem.ready = 1'b0; dmem.rvalid = 1'b0;
  endtask

  // Non-memory instructions with stray responses: no stall, result register holds.
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      ex_mem_valid = 1'($urandom_range(0, 1));
      ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
      dmem.rvalid = 1'($urandom_range(0, 1));
      dmem.ready  = 1'($urandom_range(0, 1));
      dmem.rdata  = rand64();
      @(negedge clk);
      check_eq("idle_stall", 64'(mem_stall), 64'd0);
      check_eq("idle_rdata", mem_read_data, model_rd);
      @(posedge clk); #1;
    end
    ex_mem_valid = 1'b0; dmem.rvalid = 1'b0; dmem.ready = 1'b0;
  endtask

  initial begin
    bit is_load;
    logic [2:0] f3;
    dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 64'd0;
    @(negedge clk);
    check_eq("rst_req", 64'(dmem.req), 64'd0);
    check_eq("rst_stall", 64'(mem_stall), 64'd0);
    check_eq("rst_rdata", mem_read_data, 64'd0);
    check_eq("rst_be", 64'(dmem.be), 64'd0);
    check_eq("rst_err", 64'(mem_err), 64'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    dmem.rvalid = 1'b1; dmem.rdata = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rvalid", mem_read_data, 64'd0);
    @(posedge clk); #1;

    run_txn("t1_ld", 1'b1, F3_D, 64'h1000, 64'd0, 64'h1122334455667788, 0, 1);
    check_eq("t1_value", mem_read_data, 64'h1122334455667788);
    run_txn("t2_lb", 1'b1, F3_B, 64'h1003, 64'd0, 64'h1122334480667788, 0, 1);
    check_eq("t2_lb_value", mem_read_data, 64'hFFFFFFFFFFFFFF80);
    run_txn("t2_lbu", 1'b1, F3_BU, 64'h1003, 64'd0, 64'h1122334480667788, 0, 1);
    check_eq("t2_lbu_value", mem_read_data, 64'h0000000000000080);
    run_txn("t3_sh", 1'b0, F3_H, 64'h2006, 64'hBEEF, 64'd0, 0, 1);
    check_eq("t3_rdata_kept", mem_read_data, 64'h80);
    run_txn("t4_ready_late", 1'b1, F3_W, 64'h3004, 64'd0, 64'h89ABCDEF01234567, 3, 0);

    // Reset while waiting for the response.
    ex_mem_valid = 1'b1; ex_mem_memread = 1'b1; ex_mem_funct3 = F3_D; ex_mem_alu = 64'h3008;
    dmem.ready = 1'b1; dmem.rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem.ready = 1'b0;
    @(negedge clk);
    check_eq("t5_wait_stall", 64'(mem_stall), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_req_async", 64'(dmem.req), 64'd0);
    check_eq("t5_stall_async", 64'(mem_stall), 64'd0);
    check_eq("t5_rdata_async", mem_read_data, 64'd0);
    ex_mem_valid = 1'b0; ex_mem_memread = 1'b0;
    model_rd = 64'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    dmem.rvalid = 1'b1; dmem.rdata = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    @(negedge clk);
    check_eq("t5_late_rvalid", mem_read_data, 64'd0);
    check_eq("t5_late_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    run_txn("t5_next_ld", 1'b1, F3_D, 64'h3008, 64'd0, 64'h0F1E2D3C4B5A6978, 0, 2);

    for (int t = 0; t < 40; t++) begin
      is_load = 1'($urandom_range(0, 1));
      f3 = is_load ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", t), is_load, f3, rand64(), rand64(), rand64(),
              $urandom_range(0, 3), $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

`ifdef DMEM_TIMEOUT_EN
    run_txn("t6_timeout", 1'b1, F3_D, 64'h4000, 64'd0, 64'h1234, 0, -1);
    dmem.rvalid = 1'b1; dmem.rdata = 64'hFFFF0000FFFF0000;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    @(negedge clk);
    check_eq("t6_late_rdata", mem_read_data, 64'd0);
    check_eq("t6_err_cleared", 64'(mem_err), 64'd0);
    @(posedge clk); #1;
`endif

    idle_cycles(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
